spi_bus_arbiter: RTL and testbench

- Shares one SPI master pin set (sclk/ss/mosi/miso, as on spi0) between NUM_REQ on-chip requesters.
- Grants the bus round-robin for a whole transaction; ss is held low from the first byte to the byte flagged last.
- Serializes each byte in SPI mode 0, MSB first, and returns each received byte to the owner.
- Sits between the peripheral bus masters and the SPI pads in the top level.

---
 rtl/spi_bus_arbiter_pkg.sv | 42 ++++
 rtl/spi_bus_arbiter_shifter.sv | 83 ++++++++
 rtl/spi_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter_pkg
//  Purpose  : Shared state encoding, byte width and round-robin pick helper
//             for the SPI bus arbiter.
//  Revision : 1.0
// ============================================================================
package spi_bus_arbiter_pkg;

  localparam int unsigned C_BYTE_W  = 8;
  localparam int unsigned C_MAX_REQ = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // First valid requester at or after ptr, wrapping at num; returns ptr if none.
  function automatic logic [1:0] rr_pick(input logic [C_MAX_REQ-1:0] valid,
                                         input logic [1:0]           ptr,
                                         input logic [2:0]           num);
    logic [1:0] pick;
    logic       found;
    logic [2:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < C_MAX_REQ; i++) begin
      idx = {1'b0, ptr} + 3'(i);
      if (idx >= num) idx = idx - num;
      if (!found && (3'(i) < num) && valid[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter_shifter
//  Purpose  : SPI mode-0 byte engine: sclk divider, bit counter, MSB-first
//             shift-out and miso capture on each rising sclk.
//  Revision : 1.0
// ============================================================================
module spi_bus_arbiter_shifter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [C_BYTE_W-1:0] tx_byte,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic                done,
  output logic [C_BYTE_W-1:0] rx_byte
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic                r_active;
  logic                r_phase;
  logic [DIV_W-1:0]    r_div;
  logic [2:0]          r_bit;
  logic [C_BYTE_W-1:0] r_sr;
  logic [C_BYTE_W-1:0] r_rx;
  logic                r_done;
  logic                w_half_end;

  assign w_half_end = (r_div == C_DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sr     <= '0;
      r_rx     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_active <= 1'b1;
        r_phase  <= 1'b0;
        r_div    <= '0;
        r_bit    <= '0;
        r_sr     <= tx_byte;
      end else if (r_active) begin
        // First cycle of the high half is the rising sclk edge.
        if (r_phase && (r_div == '0)) r_rx <= {r_rx[C_BYTE_W-2:0], miso};
        if (w_half_end) begin
          r_div   <= '0;
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_sr  <= {r_sr[C_BYTE_W-2:0], 1'b0};
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  // Bit 7 is presented combinationally in the load cycle, ahead of the register.
  assign mosi    = start ? tx_byte[C_BYTE_W-1] : r_sr[C_BYTE_W-1];
  assign sclk    = r_active & r_phase;
  assign done    = r_done;
  assign rx_byte = r_rx;

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter
//  Purpose  : Round-robin sharing of one SPI master among NUM_REQ requesters,
//             one whole transaction per grant.
//  Options  : SPI_BUS_ARBITER_TIMEOUT_EN adds err and a LOAD stall timeout.
//  Revision : 1.0
// ============================================================================
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [C_BYTE_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [C_BYTE_W-1:0]          rsp_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         spi_sclk,
  output logic                         spi_ss,
  output logic                         spi_mosi,
  input  logic                         spi_miso
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  ,
  output logic                         err
`endif
);

  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(CS_GAP - 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [1:0]                  r_owner;
  logic [1:0]                  r_ptr;
  logic [NUM_REQ-1:0]          r_grant;
  logic                        r_last;
  logic [GAP_W-1:0]            r_gap_cnt;

  logic [C_MAX_REQ-1:0]        w_valid_pad;
  logic [C_MAX_REQ-1:0]        w_last_pad;
  logic [C_BYTE_W*C_MAX_REQ-1:0] w_data_pad;
  logic [1:0]                  w_pick;
  logic [NUM_REQ-1:0]          w_owner_onehot;
  logic [NUM_REQ-1:0]          w_pick_onehot;
  logic                        w_start;
  logic                        w_ready;
  logic                        w_rsp;
  logic                        w_gap_done;
  logic                        w_shift_done;

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] C_STALL_LAST = STALL_W'(TIMEOUT - 1);
  logic [STALL_W-1:0] r_stall;
  logic               w_timeout;
`else
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    w_valid_pad = '0;
    w_last_pad  = '0;
    w_data_pad  = '0;
    w_valid_pad[NUM_REQ-1:0]          = req_valid;
    w_last_pad[NUM_REQ-1:0]           = req_last;
    w_data_pad[C_BYTE_W*NUM_REQ-1:0]  = req_data;
  end

  assign w_pick         = rr_pick(w_valid_pad, r_ptr, 3'(NUM_REQ));
  assign w_owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_pick_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_ready      = 1'b0;
    w_rsp        = 1'b0;
    w_gap_done   = 1'b0;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      IDLE:  if (|req_valid) w_state_next = LOAD;
      LOAD: begin
        if (w_valid_pad[r_owner]) begin
          w_start      = 1'b1;
          w_ready      = 1'b1;
          w_state_next = SHIFT;
        end
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
        else if (r_stall == C_STALL_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = GAP;
        end
`endif
      end
      SHIFT: if (w_shift_done) w_state_next = DONE;
      DONE: begin
        w_rsp        = 1'b1;
        w_state_next = r_last ? GAP : LOAD;
      end
      GAP: begin
        if (r_gap_cnt == C_GAP_LAST) begin
          w_gap_done   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner   <= '0;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_last    <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && (|req_valid)) begin
        r_owner <= w_pick;
        r_grant <= w_pick_onehot;
      end
      if (w_start) r_last <= w_last_pad[r_owner];
      if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                r_gap_cnt <= '0;
      // The pointer moves only when a transaction fully releases the bus.
      if (w_gap_done) begin
        r_grant <= '0;
        r_ptr   <= (r_owner == 2'(NUM_REQ - 1)) ? 2'd0 : r_owner + 2'd1;
      end
    end
  end

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset)                                           r_stall <= '0;
    else if ((r_state == LOAD) && !w_valid_pad[r_owner]) r_stall <= r_stall + 1'b1;
    else                                                 r_stall <= '0;
  end
  assign err = w_timeout;
`endif

  spi_bus_arbiter_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .tx_byte (w_data_pad[{r_owner, 3'b000} +: C_BYTE_W]),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .done    (w_shift_done),
    .rx_byte (rsp_data)
  );

  assign req_ready = w_ready ? w_owner_onehot : '0;
  assign rsp_valid = w_rsp   ? w_owner_onehot : '0;
  assign grant     = r_grant;
  assign busy      = (r_state != IDLE);
  assign spi_ss    = (r_state == IDLE) || (r_state == GAP);

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_bus_arbiter
//  Purpose  : Directed bench with a transaction-timeline reference model.
//  Revision : 1.0
// ============================================================================
module tb_spi_bus_arbiter;

  localparam int N = 2;
  localparam int D = 4;
  localparam int G = 2;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  localparam int TO        = 10;
  localparam int STALL_CYC = 8;
`else
  localparam int TO        = 255;
  localparam int STALL_CYC = 20;
`endif
  localparam int BYTE_CYC = 16*D + 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready, rsp_valid, grant;
  logic [7:0]     rsp_data;
  logic           busy, spi_sclk, spi_ss, spi_mosi, spi_miso;
  logic           miso_tie1 = 1'b0;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  logic           err;
`endif

  assign spi_miso = miso_tie1 ? 1'b1 : spi_mosi;

  spi_bus_arbiter #(.NUM_REQ(N), .CLK_DIV(D), .CS_GAP(G), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .grant(grant), .busy(busy), .spi_sclk(spi_sclk),
    .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bus owner, cycles since byte acceptance, gap countdown.
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_t = -1;
  int         m_gap = 0;
  int         m_stall = 0;
  logic [7:0] m_tx = '0;
  logic       m_last = 1'b0;
  logic       m_rx_tie1 = 1'b0;
  bit         m_known = 1'b0;

  // Monitor state for the hand-computed literal checks.
  int   cyc = 0;
  int   ready_cnt, ready_cyc, rsp_cyc, rises, last_rise, min_sp, max_sp, gap_cyc, ss_rises, err_cnt;
  logic [7:0] mon_bits;
  logic prev_sclk = 1'b0;
  logic prev_ss = 1'b1;
  int         rsp_owner_q[$];
  logic [7:0] rsp_data_q[$];

  always @(negedge clk) begin : model
    logic [N-1:0] e_grant, e_ready, e_rsp;
    logic         e_busy, e_ss, e_sclk, e_mosi, chk_mosi, e_err;
    logic [7:0]   e_rx;
    bit           found;
    int           idx;
    cyc++;
    e_grant = '0; e_ready = '0; e_rsp = '0;
    e_busy = 1'b0; e_ss = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; chk_mosi = 1'b0;
    e_err = 1'b0; e_rx = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_busy = 1'b1;
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (m_t < 0) begin
        e_ss = 1'b0;
        if (req_valid[m_owner]) begin
          e_ready[m_owner] = 1'b1;
          m_tx      = req_data[8*m_owner +: 8];
          m_last    = req_last[m_owner];
          m_rx_tie1 = miso_tie1;
          m_t       = 1;
          m_stall   = 0;
        end else begin
          m_stall++;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
          if (m_stall == TO) begin
            e_err   = 1'b1;
            m_gap   = G;
            m_stall = 0;
          end
`endif
        end
      end else begin
        e_ss = 1'b0;
        if (m_t <= 16*D) begin
          e_sclk = (((m_t - 1) / D) % 2) == 1;
          if (e_sclk) begin
            chk_mosi = 1'b1;
            e_mosi   = m_tx[7 - (m_t - 1) / (2*D)];
          end
        end
        if (m_t == 16*D + 2) begin
          e_rsp[m_owner] = 1'b1;
          e_rx = m_rx_tie1 ? 8'hFF : m_tx;
          m_t  = -1;
          if (m_last) m_gap = G;
        end else begin
          m_t++;
        end
      end
    end else if (|req_valid) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req_valid[idx]) begin
          m_owner = idx;
          found   = 1'b1;
        end
      end
      m_t = -1;
    end

    if (m_known) begin
      check("grant", grant, e_grant);
      check("busy", busy, e_busy);
      check("spi_ss", spi_ss, e_ss);
      check("spi_sclk", spi_sclk, e_sclk);
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, e_rsp);
      if (|e_rsp) check("rsp_data", rsp_data, e_rx);
      if (chk_mosi) check("spi_mosi", spi_mosi, e_mosi);
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
      check("err", err, e_err);
`endif
    end

    if (reset) begin
      m_owner = -1; m_ptr = 0; m_t = -1; m_gap = 0; m_stall = 0;
      m_known = 1'b1;
    end

    if (|req_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
    if (|rsp_valid) begin
      rsp_owner_q.push_back(rsp_valid[1] ? 1 : 0);
      rsp_data_q.push_back(rsp_data);
      rsp_cyc = cyc;
    end
    if (spi_sclk && !prev_sclk) begin
      if (rises > 0) begin
        if (cyc - last_rise < min_sp) min_sp = cyc - last_rise;
        if (cyc - last_rise > max_sp) max_sp = cyc - last_rise;
      end
      rises++;
      last_rise = cyc;
      mon_bits  = {mon_bits[6:0], spi_mosi};
    end
    if (spi_ss && busy) gap_cyc++;
    if (spi_ss && !prev_ss) ss_rises++;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    if (err) err_cnt++;
`endif
    prev_sclk = spi_sclk;
    prev_ss   = spi_ss;
  end

  task automatic clear_mon();
    ready_cnt = 0; ready_cyc = 0; rsp_cyc = 0; rises = 0; last_rise = 0;
    min_sp = 1000000; max_sp = 0; gap_cyc = 0; ss_rises = 0; err_cnt = 0;
    mon_bits = '0;
    rsp_owner_q.delete();
    rsp_data_q.delete();
  endtask

  // Called just after a posedge; returns just after the posedge ending the accept cycle.
  task automatic send_byte(input int i, input logic [7:0] d, input logic l);
    bit got;
    req_valid[i]       = 1'b1;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    check("send_accept_timeout", got, 1'b1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_last[i]  = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 3000 && !idle; c++) begin
      @(negedge clk);
      if (!busy && !(|req_valid)) idle = 1'b1;
    end
    check("idle_timeout", idle, 1'b1);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rsp_at(input int k);
    return (rsp_data_q.size() > k) ? rsp_data_q[k] : 8'hxx;
  endfunction

  function automatic int owner_at(input int k);
    return (rsp_owner_q.size() > k) ? rsp_owner_q[k] : -1;
  endfunction

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ss", spi_ss, 1'b1);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);

    // Single-byte loopback from req0.
    clear_mon();
    send_byte(0, 8'hA5, 1'b1);
    wait_idle();
    check("t1_rsp_count", rsp_data_q.size(), 1);
    check("t1_rsp_data", rsp_at(0), 8'hA5);
    check("t1_rsp_owner", owner_at(0), 0);
    check("t1_latency", rsp_cyc - ready_cyc, 66);
    check("t1_mosi_bits", mon_bits, 8'hA5);
    check("t1_sclk_pulses", rises, 8);
    check("t1_sclk_min_period", min_sp, 8);
    check("t1_sclk_max_period", max_sp, 8);
    check("t1_ss_gap", gap_cyc, 2);

    // Three-byte transaction from req1 with miso tied high.
    clear_mon();
    miso_tie1 = 1'b1;
    send_byte(1, 8'h01, 1'b0);
    send_byte(1, 8'h02, 1'b0);
    send_byte(1, 8'h03, 1'b1);
    wait_idle();
    miso_tie1 = 1'b0;
    check("t2_rsp_count", rsp_data_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("t2_rsp_data", rsp_at(k), 8'hFF);
      check("t2_rsp_owner", owner_at(k), 1);
    end
    check("t2_ss_rises", ss_rises, 1);
    check("t2_ready_cnt", ready_cnt, 3);

    // Two rounds of simultaneous single-byte requests.
    clear_mon();
    fork
      send_byte(0, 8'h11, 1'b1);
      send_byte(1, 8'h22, 1'b1);
    join
    wait_idle();
    fork
      send_byte(0, 8'h33, 1'b1);
      send_byte(1, 8'h44, 1'b1);
    join
    wait_idle();
    check("t3_owner0", owner_at(0), 0);
    check("t3_owner1", owner_at(1), 1);
    check("t3_owner2", owner_at(2), 0);
    check("t3_owner3", owner_at(3), 1);
    check("t3_data0", rsp_at(0), 8'h11);
    check("t3_data3", rsp_at(3), 8'h44);

    // Owner stalls between bytes.
    clear_mon();
    send_byte(0, 8'h3C, 1'b0);
    repeat (BYTE_CYC + STALL_CYC - 1) @(posedge clk);
    #1;
    check("t4_stall_ready", ready_cnt, 1);
    check("t4_stall_ss", spi_ss, 1'b0);
    check("t4_stall_sclk", spi_sclk, 1'b0);
    send_byte(0, 8'hC3, 1'b1);
    wait_idle();
    check("t4_rsp0", rsp_at(0), 8'h3C);
    check("t4_rsp1", rsp_at(1), 8'hC3);
    check("t4_ready_cnt", ready_cnt, 2);

    // Reset during bit 3 of a req1 transfer.
    clear_mon();
    send_byte(1, 8'h5A, 1'b1);
    repeat (26) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_ss", spi_ss, 1'b1);
    check("t5_sclk", spi_sclk, 1'b0);
    check("t5_grant", grant, 2'b00);
    check("t5_busy", busy, 1'b0);
    repeat (80) @(posedge clk);
    #1;
    check("t5_no_rsp", rsp_data_q.size(), 0);
    fork
      send_byte(0, 8'h66, 1'b1);
      send_byte(1, 8'h77, 1'b1);
    join
    wait_idle();
    check("t5_first_owner", owner_at(0), 0);

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    // Owner stalls past the limit while req1 waits.
    clear_mon();
    send_byte(0, 8'h81, 1'b0);
    send_byte(1, 8'h18, 1'b1);
    wait_idle();
    check("t6_err_cnt", err_cnt, 1);
    check("t6_owner0", owner_at(0), 0);
    check("t6_owner1", owner_at(1), 1);
    check("t6_rsp_count", rsp_data_q.size(), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
